pwm_dds_voice: RTL and testbench

//  Audio voice stage fed by the note sequencer's o_top/o_top_valid/o_phase_delta outputs.
//  - 32-bit phase accumulator advances by the incoming phase delta every clock.
//  - Accumulator top byte selects a waveform sample: square, saw, triangle or silence.
//  - The sample is scaled to the programmable PWM period and drives a single-bit PWM pin for the speaker.

---
 rtl/pwm_dds_voice.sv | 120 ++++++++++++
 tb/tb_pwm_dds_voice.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dds_voice.sv
// pwm_dds_voice: DDS phase accumulator feeding a waveform lookup whose sample
// is rescaled to a programmable PWM period and emitted on a single-bit pin.
// Period length and duty are only ever updated on the period boundary, so a
// mid-period change to i_top or to the waveform never produces a short or
// glitched period.
module pwm_dds_voice #(
  parameter int PHASE_WIDTH  = 32,
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [PHASE_WIDTH-1:0]  i_phase_delta,
  input  logic [SAMPLE_WIDTH-1:0] i_top,
  input  logic                    i_top_valid,
  input  logic [1:0]              i_wave_sel,
  output logic                    o_pwm,
  output logic [SAMPLE_WIDTH-1:0] o_sample,
  output logic                    o_period_start
);

  localparam int PROD_WIDTH = 2 * SAMPLE_WIDTH;

  logic [PHASE_WIDTH-1:0]  r_phase;
  logic [SAMPLE_WIDTH-1:0] r_cnt;
  logic [SAMPLE_WIDTH-1:0] r_top;
  logic [SAMPLE_WIDTH-1:0] r_top_pend;
  logic                    r_pend;
  logic [SAMPLE_WIDTH-1:0] r_duty;

  logic [SAMPLE_WIDTH-1:0] p;
  logic [SAMPLE_WIDTH-1:0] raw;
  logic                    boundary;
  logic [SAMPLE_WIDTH-1:0] next_top;
  logic [SAMPLE_WIDTH:0]   top_plus;
  logic [PROD_WIDTH-1:0]   product;
  logic [SAMPLE_WIDTH-1:0] duty_scaled;
  logic [SAMPLE_WIDTH-1:0] cnt_nxt;
  logic [SAMPLE_WIDTH-1:0] duty_nxt;

  assign p = r_phase[PHASE_WIDTH-1 -: SAMPLE_WIDTH];

  // Waveform lookup from the accumulator top byte; a zero delta forces silence.
  always_comb begin
    raw = '0;
    if (i_phase_delta != '0) begin
      case (i_wave_sel)
        2'b00:   raw = p[SAMPLE_WIDTH-1] ? '1 : '0;
        2'b01:   raw = p;
        2'b10:   raw = p[SAMPLE_WIDTH-1] ? ~{p[SAMPLE_WIDTH-2:0], 1'b0}
                                         :  {p[SAMPLE_WIDTH-2:0], 1'b0};
        default: raw = '0;
      endcase
    end
  end

  // Boundary decisions: period reload, top selection and duty rescaling.
  // A valid top arriving on the boundary cycle itself wins over the shadow.
  always_comb begin
    boundary    = (r_cnt == r_top);
    next_top    = i_top_valid ? i_top : (r_pend ? r_top_pend : r_top);
    top_plus    = {1'b0, next_top} + (SAMPLE_WIDTH + 1)'(1);
    product     = {{SAMPLE_WIDTH{1'b0}}, raw} * {{(SAMPLE_WIDTH-1){1'b0}}, top_plus};
    duty_scaled = SAMPLE_WIDTH'(product >> SAMPLE_WIDTH);
    cnt_nxt     = boundary ? '0 : r_cnt + SAMPLE_WIDTH'(1);
    duty_nxt    = boundary ? duty_scaled : r_duty;
  end

  // Phase accumulator; wraps modulo 2^PHASE_WIDTH, zero delta parks it at 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase <= '0;
    end else if (i_phase_delta == '0) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + i_phase_delta;
    end
  end

  // Top shadow register: last valid before the boundary is the one applied.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_top_pend <= '0;
      r_pend     <= 1'b0;
    end else if (boundary) begin
      r_pend     <= 1'b0;
    end else if (i_top_valid) begin
      r_top_pend <= i_top;
      r_pend     <= 1'b1;
    end
  end

  // PWM period counter plus per-period latched top, duty and sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt          <= '0;
      r_top          <= '1;
      r_duty         <= '0;
      o_sample       <= '0;
      o_period_start <= 1'b0;
    end else begin
      r_cnt          <= cnt_nxt;
      r_duty         <= duty_nxt;
      o_period_start <= boundary;
      if (boundary) begin
        r_top    <= next_top;
        o_sample <= raw;
      end
    end
  end

  // Output pin registered from next-state values so it always equals cnt < duty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pwm <= 1'b0;
    end else begin
      o_pwm <= (cnt_nxt < duty_nxt);
    end
  end

endmodule

// File: tb/tb_pwm_dds_voice.sv
// tb_pwm_dds_voice: directed vector table, hand-written boundary sequences and
// a randomized run against a period-level arithmetic reference model.
module tb_pwm_dds_voice;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] delta = '0;
  logic [7:0]  top = 8'hFF;
  logic        top_valid = 1'b0;
  logic [1:0]  wave = 2'b00;
  logic        pwm;
  logic [7:0]  sample;
  logic        period_start;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  pwm_dds_voice dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_phase_delta  (delta),
    .i_top          (top),
    .i_top_valid    (top_valid),
    .i_wave_sel     (wave),
    .o_pwm          (pwm),
    .o_sample       (sample),
    .o_period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      wave;
    logic [31:0]     delta;
    logic [7:0]      top;
    logic [3:0][7:0] smp;
    logic [3:0][8:0] hi;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Leaves the bench at the negedge of the first cycle after reset (cyc=0).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    top_valid = 1'b0;
    repeat (3) @(negedge clk);
    cyc = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " pwm"}, int'(pwm), 0);
    chk({tag, " sample"}, int'(sample), 0);
    chk({tag, " period_start"}, int'(period_start), 0);
  endtask

  task automatic wait_ps(output int at);
    at = -1;
    for (int k = 0; k < 600; k++) begin
      step();
      if (period_start) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic set_vec(input int i, input logic [1:0] w, input logic [31:0] d,
                         input logic [7:0] t,
                         input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3,
                         input int h0, input int h1, input int h2, input int h3);
    tbl[i].wave  = w;
    tbl[i].delta = d;
    tbl[i].top   = t;
    tbl[i].smp[0] = s0; tbl[i].smp[1] = s1; tbl[i].smp[2] = s2; tbl[i].smp[3] = s3;
    tbl[i].hi[0] = 9'(h0); tbl[i].hi[1] = 9'(h1); tbl[i].hi[2] = 9'(h2); tbl[i].hi[3] = 9'(h3);
  endtask

  // Reference model state: one entry per observable quantity of the current cycle.
  longint unsigned m_ph;
  int m_pos, m_len, m_pend, m_duty, m_smp, m_ps;

  function automatic int raw_of(longint unsigned ph, int w, longint unsigned d);
    int pp;
    pp = int'(ph >> 24);
    if (d == 0) return 0;
    case (w)
      0: return (pp >= 128) ? 255 : 0;
      1: return pp;
      2: return (pp < 128) ? 2 * pp : 255 - 2 * (pp - 128);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_pos = 0; m_len = 256; m_pend = -1; m_duty = 0; m_smp = 0; m_ps = 0;
  endtask

  task automatic model_edge(input bit r, input longint unsigned d, input int t,
                            input bit v, input int w);
    int raw, nt;
    if (r) begin
      model_reset();
      return;
    end
    raw = raw_of(m_ph, w, d);
    if (m_pos == m_len - 1) begin
      nt = v ? t : ((m_pend >= 0) ? m_pend : m_len - 1);
      m_len = nt + 1;
      m_pos = 0;
      m_pend = -1;
      m_duty = (raw * (nt + 1)) / 256;
      m_smp = raw;
      m_ps = 1;
    end else begin
      m_pos++;
      m_ps = 0;
      if (v) m_pend = t;
    end
    m_ph = (d == 0) ? 0 : ((m_ph + d) % 64'h1_0000_0000);
  endtask

  initial begin
    int per, hi, at;
    bit done;

    //       wave   delta          top    samples (periods 2..5)       highs
    set_vec(0, 2'b00, 32'h0000_0000, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    set_vec(1, 2'b00, 32'h0080_0000, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 0, 255, 0, 255);
    set_vec(2, 2'b00, 32'h0080_0000, 8'h7F, 8'h00, 8'hFF, 8'hFF, 8'h00, 0, 127, 127, 0);
    set_vec(3, 2'b01, 32'h0040_0000, 8'hFF, 8'h3F, 8'h7F, 8'hBF, 8'hFF, 63, 127, 191, 255);
    set_vec(4, 2'b10, 32'h0040_0000, 8'hFF, 8'h7E, 8'hFE, 8'h81, 8'h01, 126, 254, 129, 1);
    set_vec(5, 2'b11, 32'h0040_0000, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    set_vec(6, 2'b01, 32'h0040_0000, 8'h0F, 8'h3F, 8'h43, 8'h47, 8'h4B, 3, 4, 4, 4);
    set_vec(7, 2'b01, 32'h0040_0000, 8'h00, 8'h3F, 8'h40, 8'h40, 8'h40, 0, 0, 0, 0);

    // Vector table: reset, program inputs in cycle 0, observe four periods.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      chk_zero($sformatf("vec%0d reset", i));
      rst = 1'b0;
      wave = tbl[i].wave;
      delta = tbl[i].delta;
      top = tbl[i].top;
      top_valid = 1'b1;
      step();
      top_valid = 1'b0;
      per = 0; hi = 0; done = 1'b0;
      while (!done && cyc < 1400) begin
        if (period_start) begin
          if (per == 0) begin
            chk($sformatf("vec%0d first period_start cycle", i), cyc, 256);
            chk($sformatf("vec%0d first period pwm high", i), hi, 0);
          end else begin
            chk($sformatf("vec%0d period%0d pwm high", i, per + 1), hi, int'(tbl[i].hi[per-1]));
          end
          if (per < 4)
            chk($sformatf("vec%0d period%0d sample", i, per + 2), int'(sample), int'(tbl[i].smp[per]));
          per++;
          hi = 0;
          if (per == 5) done = 1'b1;
        end
        hi += int'(pwm);
        if (!done) step();
      end
      if (!done) chk($sformatf("vec%0d periods seen before timeout", i), per, 5);
    end

    // Top change mid-period: current 256-cycle period completes, then 16-cycle periods.
    do_reset();
    rst = 1'b0; wave = 2'b00; delta = 32'h0080_0000; top = 8'hFF; top_valid = 1'b0;
    while (cyc < 100) step();
    top = 8'h0F; top_valid = 1'b1;
    step();
    top_valid = 1'b0; top = 8'hFF;
    wait_ps(at); chk("topchg ps1 cycle", at, 256);
    wait_ps(at); chk("topchg ps2 cycle", at, 272);
    wait_ps(at); chk("topchg ps3 cycle", at, 288);

    // Reset mid-period with a pending top: pending is dropped, 256-cycle periods follow.
    do_reset();
    rst = 1'b0; wave = 2'b00; delta = 32'h0080_0000; top = 8'hFF; top_valid = 1'b0;
    while (cyc < 40) step();
    top = 8'h0F; top_valid = 1'b1;
    step();
    top_valid = 1'b0; top = 8'hFF;
    while (cyc < 50) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("midrst");
    wait_ps(at); chk("midrst ps1 cycle", at, 51 + 256);
    wait_ps(at); chk("midrst ps2 cycle", at, 51 + 512);

    // Randomized run against the reference model, with occasional resets.
    do_reset();
    model_reset();
    rst = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      chk("rand pwm", int'(pwm), (m_pos < m_duty) ? 1 : 0);
      chk("rand sample", int'(sample), m_smp);
      chk("rand period_start", int'(period_start), m_ps);
      begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0)      delta = 32'h0;
        else if (r < 5)  delta = $urandom;
        else             delta = $urandom_range(1, 32'h0400_0000);
        top = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
        top_valid = ($urandom_range(0, 15) == 0);
        wave = 2'($urandom_range(0, 3));
        rst = ($urandom_range(0, 399) == 0);
      end
      model_edge(rst, longint'(delta), int'(top), top_valid, int'(wave));
      step();
    end
    rst = 1'b0;
    top_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
